// File: rtl/uart_alu_intf.sv
// Collects operand A, operand B and opcode bytes from uart_rx, drives the external ALU and hands the result to uart_tx.
// Optional inter-byte timeout in WAIT_B/WAIT_OP is enabled by defining UART_ALU_INTF_TIMEOUT_EN.
module uart_alu_intf #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_op,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_overrun,
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   timeout_hit;
    logic   busy_state;

    assign busy_state = (state_q == EXEC) || (state_q == SEND) || (state_q == WAIT_TX);
    assign o_busy     = busy_state;
    assign o_tx_start = (state_q == SEND);
    assign dbg_state  = state_q;

`ifdef UART_ALU_INTF_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt_q;
    logic             counting;

    // Counter is held at zero outside the byte-waiting states, so entry always starts from zero.
    assign counting    = (state_q == WAIT_B) || (state_q == WAIT_OP);
    assign timeout_hit = counting && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (i_rst || !counting || i_rx_done || timeout_hit) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= WAIT_A;
        end else begin
            state_q <= state_d;
        end
    end

    // A byte arriving in the same cycle as a timeout expiry is accepted, so i_rx_done is tested first.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_A:  if (i_rx_done) state_d = WAIT_B;
            WAIT_B: begin
                if (i_rx_done)        state_d = WAIT_OP;
                else if (timeout_hit) state_d = WAIT_A;
            end
            WAIT_OP: begin
                if (i_rx_done)        state_d = EXEC;
                else if (timeout_hit) state_d = WAIT_A;
            end
            EXEC:    state_d = SEND;
            SEND:    state_d = WAIT_TX;
            WAIT_TX: if (i_tx_done) state_d = WAIT_A;
            default: state_d = WAIT_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_data_a  <= '0;
            o_data_b  <= '0;
            o_op      <= '0;
            o_tx_data <= '0;
            o_overrun <= 1'b0;
        end else begin
            o_overrun <= i_rx_done && busy_state;
            case (state_q)
                WAIT_A:  if (i_rx_done) o_data_a <= i_rx_data;
                WAIT_B:  if (i_rx_done) o_data_b <= i_rx_data;
                WAIT_OP: if (i_rx_done) o_op <= i_rx_data[NB_OP-1:0];
                EXEC:    o_tx_data <= i_alu_result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_intf.sv
// Randomized scoreboard bench for uart_alu_intf; define UART_ALU_INTF_TIMEOUT_EN to exercise the timeout build.
module tb_uart_alu_intf;

    localparam int EXP_W = 8 + 8 + 6 + 8 + 32;
`ifdef UART_ALU_INTF_TIMEOUT_EN
    localparam int TMO = 100;
`else
    localparam int TMO = 50_000_000;
`endif

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [7:0] i_rx_data = '0;
    logic       i_rx_done = 1'b0;
    logic [7:0] i_alu_result;
    logic       i_tx_done = 1'b0;
    logic [7:0] o_data_a, o_data_b, o_tx_data;
    logic [5:0] o_op;
    logic       o_tx_start, o_busy, o_overrun;
    logic [2:0] dbg_state;

    int          tests = 0;
    int          fails = 0;
    int          exp_ovr = 0;
    int          ovr_seen = 0;
    logic [31:0] cyc = '0;
    logic        prev_start = 1'b0;
    logic [EXP_W-1:0] exp_q[$];

    uart_alu_intf #(.NB_DATA(8), .NB_OP(6), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
        .i_alu_result(i_alu_result), .i_tx_done(i_tx_done),
        .o_data_a(o_data_a), .o_data_b(o_data_b), .o_op(o_op), .o_tx_data(o_tx_data),
        .o_tx_start(o_tx_start), .o_busy(o_busy), .o_overrun(o_overrun), .dbg_state(dbg_state)
    );

    // External ALU: ADD, SUB, anything else XOR.
    assign i_alu_result = (o_op == 6'h20) ? o_data_a + o_data_b :
                          (o_op == 6'h22) ? o_data_a - o_data_b : o_data_a ^ o_data_b;

    // Clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: result from the received bytes with plain modular arithmetic.
    function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb);
        int r;
        case (opb % 64)
            32:      r = (int'(a) + int'(b)) % 256;
            34:      r = (int'(a) - int'(b) + 256) % 256;
            default: r = int'(a ^ b);
        endcase
        return r[7:0];
    endfunction

    // Driver tasks
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic [31:0] dc);
        @(negedge clk);
        i_rx_data = b;
        i_rx_done = 1'b1;
        dc = cyc;
        @(negedge clk);
        i_rx_done = 1'b0;
    endtask

    task automatic push_exp(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                            input logic [31:0] dc);
        logic [5:0] op6;
        op6 = 6'(opb % 64);
        exp_q.push_back({a, b, op6, model(a, b, opb), dc});
    endtask

    // After the opcode byte: wait for tx_start, then finish the handshake in one of three ways.
    task automatic complete(input logic [7:0] a, input int mode);
        logic        ok;
        logic [31:0] dc;
        int          d;
        check("busy_exec", {31'b0, o_busy}, 1);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (o_tx_start) ok = 1'b1;
        end
        check("tx_start_seen", {31'b0, ok}, 1);
        if (!ok) return;
        case (mode)
            1: begin
                exp_ovr++;
                send_byte(8'hAA, dc);
                check("overrun_pulse", {31'b0, o_overrun}, 1);
                check("overrun_keep_a", {24'b0, o_data_a}, {24'b0, a});
                check("overrun_busy", {31'b0, o_busy}, 1);
                @(negedge clk);
                check("overrun_clear", {31'b0, o_overrun}, 0);
                @(negedge clk);
                i_tx_done = 1'b1;
                @(negedge clk);
                i_tx_done = 1'b0;
                check("busy_idle", {31'b0, o_busy}, 0);
            end
            2: begin
                @(negedge clk);
                exp_ovr++;
                i_rx_data = 8'($urandom);
                i_rx_done = 1'b1;
                i_tx_done = 1'b1;
                @(negedge clk);
                i_rx_done = 1'b0;
                i_tx_done = 1'b0;
                check("simul_overrun", {31'b0, o_overrun}, 1);
                check("simul_idle", {31'b0, o_busy}, 0);
                check("simul_keep_a", {24'b0, o_data_a}, {24'b0, a});
            end
            default: begin
                d = $urandom_range(5, 1);
                repeat (d) begin
                    @(negedge clk);
                    check("busy_wait_tx", {31'b0, o_busy}, 1);
                end
                @(negedge clk);
                i_tx_done = 1'b1;
                @(negedge clk);
                i_tx_done = 1'b0;
                check("busy_idle", {31'b0, o_busy}, 0);
            end
        endcase
    endtask

    task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb, input int mode);
        logic [31:0] dc;
        send_byte(a, dc);
        idle($urandom_range(3, 0));
        send_byte(b, dc);
        idle($urandom_range(3, 0));
        send_byte(opb, dc);
        push_exp(a, b, opb, dc);
        complete(a, mode);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {o_data_a, o_data_b, 2'b0, o_op, o_tx_data},  0);
        check({name, "_ctl"}, {29'b0, o_tx_start, o_busy, o_overrun}, 0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (o_overrun) ovr_seen++;
        if (o_tx_start) begin
            check("start_single", {31'b0, prev_start}, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_start", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("data_a", {24'b0, o_data_a}, {24'b0, e[61:54]});
                check("data_b", {24'b0, o_data_b}, {24'b0, e[53:46]});
                check("op", {26'b0, o_op}, {26'b0, e[45:40]});
                check("tx_data", {24'b0, o_tx_data}, {24'b0, e[39:32]});
                check("start_latency", cyc, e[31:0] + 2);
            end
        end
        prev_start = o_tx_start;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] dc;
        logic [7:0]  opb;
        int          m;
        idle(3);
        check_all_zero("reset_outputs");
        i_rst = 1'b0;
        idle(2);
        check_all_zero("idle_after_reset");

        txn(8'h05, 8'h03, 8'h20, 0);
        txn(8'hFF, 8'h02, 8'hE2, 0);
        txn(8'h80, 8'h80, 8'h20, 0);
        txn(8'h10, 8'h04, 8'h22, 1);
        txn(8'h01, 8'h09, 8'h20, 0);

        // Reset mid-transaction; a byte strobed during reset must be ignored.
        send_byte(8'h11, dc);
        send_byte(8'h22, dc);
        @(negedge clk);
        i_rst = 1'b1;
        i_rx_done = 1'b1;
        i_rx_data = 8'h55;
        @(negedge clk);
        i_rst = 1'b0;
        i_rx_done = 1'b0;
        check_all_zero("mid_reset");
        txn(8'h01, 8'h01, 8'h20, 0);

        txn(8'h33, 8'h44, 8'h20, 2);
        txn(8'h21, 8'h12, 8'h22, 0);

        // Long gap after operand A.
        send_byte(8'h07, dc);
        idle(100);
`ifdef UART_ALU_INTF_TIMEOUT_EN
        txn(8'h02, 8'h03, 8'h20, 0);
`else
        send_byte(8'h02, dc);
        send_byte(8'h03, dc);
        push_exp(8'h07, 8'h02, 8'h03, dc);
        complete(8'h07, 0);
`endif

        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(2, 0))
                0:       opb = {2'($urandom), 6'h20};
                1:       opb = {2'($urandom), 6'h22};
                default: opb = 8'($urandom);
            endcase
            m = ($urandom_range(3, 0) == 0) ? int'($urandom_range(2, 1)) : 0;
            txn(8'($urandom), 8'($urandom), opb, m);
        end

        idle(5);
        check("exp_q_empty", exp_q.size(), 0);
        check("overrun_count", ovr_seen, exp_ovr);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_alu_intf.md
Name: uart_alu_intf

Overview:
Downstream consumer of uart_rx in the UART-ALU datapath. Collects three received bytes in order: operand A, operand B, opcode. Presents them to the external combinational ALU, captures the ALU result and hands it to uart_tx with a start/done handshake. Runs on the system clock and consumes uart_rx's one-cycle o_rxdone pulse directly; it does not use baud ticks.

Parameters:
NB_DATA, 8, width of received bytes, operands, result and TX byte
NB_OP, 6, opcode width; low NB_OP bits of the third byte
TIMEOUT_CYCLES, 50_000_000, inter-byte timeout in clk cycles; used only with UART_ALU_INTF_TIMEOUT_EN

Ports:
clk  in  1  system clock, all logic on rising edge
i_rst  in  1  synchronous reset, active-high
i_rx_data  in  NB_DATA  byte from uart_rx o_data
i_rx_done  in  1  one-cycle strobe from uart_rx o_rxdone; i_rx_data valid in that cycle
i_alu_result  in  NB_DATA  combinational result from external ALU
i_tx_done  in  1  one-cycle strobe from uart_tx when the byte has been fully sent
o_data_a  out  NB_DATA  registered operand A to ALU
o_data_b  out  NB_DATA  registered operand B to ALU
o_op  out  NB_OP  registered opcode to ALU
o_tx_data  out  NB_DATA  registered result byte to uart_tx
o_tx_start  out  1  one-cycle start strobe to uart_tx
o_busy  out  1  high in EXEC, SEND, WAIT_TX
o_overrun  out  1  one-cycle pulse when a received byte is dropped

Behaviour:
- Reset: all outputs 0; state WAIT_A; internal timeout counter 0. Reset has priority over every event. Reset mid-transaction abandons the transaction with no tx_start.
- States:
  - WAIT_A: on i_rx_done, o_data_a <= i_rx_data, go to WAIT_B.
  - WAIT_B: on i_rx_done, o_data_b <= i_rx_data, go to WAIT_OP.
  - WAIT_OP: on i_rx_done, o_op <= i_rx_data[NB_OP-1:0], go to EXEC. Upper byte bits are discarded.
  - EXEC: one cycle for the ALU to settle. o_tx_data <= i_alu_result. Go to SEND.
  - SEND: o_tx_start = 1 for exactly this cycle. i_tx_done is ignored. Go to WAIT_TX.
  - WAIT_TX: hold. On i_tx_done, go to WAIT_A.
- o_tx_start and o_busy are decoded from the registered state, so they are glitch-free.
- Latency: opcode i_rx_done in cycle n gives:
  - o_op valid and state EXEC in cycle n+1;
  - o_tx_data valid and o_tx_start high in cycle n+2.
- o_data_a, o_data_b and o_op hold their values until overwritten by the next transaction. o_tx_data holds until the next EXEC.
- i_rx_done in EXEC, SEND or WAIT_TX: byte dropped, o_overrun = 1 in the next cycle, state unaffected.
- Simultaneous i_rx_done and i_tx_done in WAIT_TX: transition to WAIT_A. The byte is dropped with an overrun pulse; it is not captured as A.
- i_rx_done while i_rst is high: ignored, no overrun.
- Stray i_tx_done outside WAIT_TX: ignored.

Optional Feature:
Macro UART_ALU_INTF_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_B and WAIT_OP. It clears on entry to those states and on every accepted byte.
  - When it reaches TIMEOUT_CYCLES-1 with no i_rx_done, state returns to WAIT_A. Partially received operands are kept but unused.
  - i_rx_done in the same cycle as expiry wins: the byte is accepted and no timeout occurs.
  - The counter width is $clog2(TIMEOUT_CYCLES).
- Undefined: no counter logic; WAIT_B and WAIT_OP wait indefinitely.

Test Plan:
- Bench ALU model: ADD (op 6'b100000) = A+B, SUB (op 6'b100010) = A-B.
- Basic ADD: rx bytes 0x05, 0x03, 0x20 ->
  - o_data_a=0x05, o_data_b=0x03, o_op=6'h20;
  - o_tx_data=0x08 and o_tx_start single pulse 2 cycles after the third i_rx_done;
  - o_busy high until i_tx_done.
- Wrap and opcode truncation: rx 0xFF, 0x02, 0xE2 -> o_op=6'h22 (SUB); o_tx_data=0xFD. Then rx 0x80, 0x80, 0x20 -> o_tx_data=0x00 (mod 256).
- Overrun: after the opcode, pulse i_rx_done with 0xAA during WAIT_TX -> o_overrun one-cycle pulse, no state change, o_data_a unchanged. Then i_tx_done, then 0x01 -> captured as A.
- Reset mid-op: rx 0x11, 0x22, then i_rst for 1 cycle -> all outputs 0, WAIT_A. Next bytes 0x01, 0x01, 0x20 -> o_tx_data=0x02, exactly one tx_start.
- Simultaneous event: i_rx_done and i_tx_done in the same WAIT_TX cycle -> back to WAIT_A, o_overrun pulse, next byte taken as A.
- Timeout, with UART_ALU_INTF_TIMEOUT_EN and TIMEOUT_CYCLES=100: rx 0x07, then idle 100 cycles -> WAIT_A. Then 0x02, 0x03, 0x20 -> o_tx_data=0x05. Without the macro the same stimulus gives 0x07 as A, 0x02 as B, 0x03 as op.
